// File: rtl/chan_sum_override.sv
// chan_sum_override: multi-lane, two-stage pipelined sum unit with a per-lane
// force/release override on the f result.
//   Stage 1 registers s = a + b per lane.
//   Stage 2 registers c = s, d = s + s, f = c + d (= 3s), all modulo 2^WIDTH.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   in_valid / in_ready             operand handshake (in_ready = pipeline enable)
//   in_a, in_b                      operands, lanes packed LSB-first
//   force_set, force_rel, force_val per-lane override pulses and value
//   out_valid / out_ready           result handshake
//   out_c, out_d, out_f             results; out_f shows override when forced
//   forced                          per-lane override active
module chan_sum_override #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned REL_MODE = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNELS*WIDTH-1:0] in_a,
  input  logic [CHANNELS*WIDTH-1:0] in_b,
  input  logic [CHANNELS-1:0]       force_set,
  input  logic [CHANNELS-1:0]       force_rel,
  input  logic [CHANNELS*WIDTH-1:0] force_val,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHANNELS*WIDTH-1:0] out_c,
  output logic [CHANNELS*WIDTH-1:0] out_d,
  output logic [CHANNELS*WIDTH-1:0] out_f,
  output logic [CHANNELS-1:0]       forced
);

  localparam int unsigned VW = CHANNELS * WIDTH;

  typedef enum logic {StLive, StForced} ovr_state_e;

  logic          en;
  logic          v1_q, v2_q;
  logic [VW-1:0] s_q, c_q, d_q, f_q;
  logic [VW-1:0] s_sum, d_sum, f_sum;

  ovr_state_e    state_q [CHANNELS];
  ovr_state_e    state_d [CHANNELS];
  logic [VW-1:0] ovr_q, ovr_d;
  // Lane released but still showing the held override value (reg-style release).
  logic [CHANNELS-1:0] stale_q, stale_d;

  // Whole pipeline advances together; a stalled output freezes both stages.
  assign en        = !v2_q || out_ready;
  assign in_ready  = en;
  assign out_valid = v2_q;
  assign out_c     = c_q;
  assign out_d     = d_q;

  always_comb begin
    s_sum = '0;
    d_sum = '0;
    f_sum = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      s_sum[k*WIDTH +: WIDTH] = in_a[k*WIDTH +: WIDTH] + in_b[k*WIDTH +: WIDTH];
      d_sum[k*WIDTH +: WIDTH] = s_q[k*WIDTH +: WIDTH] + s_q[k*WIDTH +: WIDTH];
      f_sum[k*WIDTH +: WIDTH] = d_sum[k*WIDTH +: WIDTH] + s_q[k*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      s_q  <= '0;
      c_q  <= '0;
      d_q  <= '0;
      f_q  <= '0;
    end else if (en) begin
      v1_q <= in_valid;
      v2_q <= v1_q;
      if (in_valid) s_q <= s_sum;
      // Data registers only move on real beats so bubbles leave results intact.
      if (v1_q) begin
        c_q <= s_q;
        d_q <= d_sum;
        f_q <= f_sum;
      end
    end
  end

  always_comb begin
    ovr_d   = ovr_q;
    stale_d = stale_q;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      state_d[k] = state_q[k];
      // A valid stage-2 update replaces the held value with live data.
      if (en && v1_q) stale_d[k] = 1'b0;
      if (force_set[k]) begin
        // Set wins over a simultaneous release and reloads when already forced.
        state_d[k]              = StForced;
        ovr_d[k*WIDTH +: WIDTH] = force_val[k*WIDTH +: WIDTH];
        stale_d[k]              = 1'b0;
      end else if (force_rel[k] && (state_q[k] == StForced)) begin
        state_d[k] = StLive;
        stale_d[k] = (REL_MODE != 0);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < CHANNELS; k++) state_q[k] <= StLive;
      ovr_q   <= '0;
      stale_q <= '0;
    end else begin
      for (int unsigned k = 0; k < CHANNELS; k++) state_q[k] <= state_d[k];
      ovr_q   <= ovr_d;
      stale_q <= stale_d;
    end
  end

  always_comb begin
    out_f  = f_q;
    forced = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      forced[k] = (state_q[k] == StForced);
      if (forced[k] || stale_q[k]) out_f[k*WIDTH +: WIDTH] = ovr_q[k*WIDTH +: WIDTH];
    end
  end

endmodule
